// File: rtl/host_device_bus_if.sv
// Host/device bus bundle for the N-host / M-device interconnect.
// slave is the interconnect's view, master is the hosts' and devices' view.
interface host_device_bus_if #(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  localparam int BeWidth = DataWidth / 8;

  logic [NrHosts-1:0]                   host_req;
  logic [NrHosts-1:0]                   host_gnt;
  logic [NrHosts-1:0][AddressWidth-1:0] host_addr;
  logic [NrHosts-1:0]                   host_we;
  logic [NrHosts-1:0][BeWidth-1:0]      host_be;
  logic [NrHosts-1:0][DataWidth-1:0]    host_wdata;
  logic [NrHosts-1:0]                   host_rvalid;
  logic [NrHosts-1:0][DataWidth-1:0]    host_rdata;
  logic [NrHosts-1:0]                   host_err;

  logic [NrDevices-1:0]                   device_req;
  logic [NrDevices-1:0][AddressWidth-1:0] device_addr;
  logic [NrDevices-1:0]                   device_we;
  logic [NrDevices-1:0][BeWidth-1:0]      device_be;
  logic [NrDevices-1:0][DataWidth-1:0]    device_wdata;
  logic [NrDevices-1:0]                   device_rvalid;
  logic [NrDevices-1:0][DataWidth-1:0]    device_rdata;
  logic [NrDevices-1:0]                   device_err;

  modport slave (
    input  host_req, host_addr, host_we, host_be, host_wdata,
    output host_gnt, host_rvalid, host_rdata, host_err,
    output device_req, device_addr, device_we, device_be,
    output device_wdata,
    input  device_rvalid, device_rdata, device_err
  );

  modport master (
    output host_req, host_addr, host_we, host_be, host_wdata,
    input  host_gnt, host_rvalid, host_rdata, host_err,
    input  device_req, device_addr, device_we, device_be,
    input  device_wdata,
    output device_rvalid, device_rdata, device_err
  );
endinterface

// File: rtl/host_device_bus.sv
// Fixed-priority N-host / M-device interconnect with mask/base decode
// and one-cycle response routing through registered selections.
module host_device_bus #(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base,
  input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_mask,
  host_device_bus_if.slave bus
);
  localparam int HostSelW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DevSelW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  logic [HostSelW-1:0]     host_sel;
  logic [HostSelW-1:0]     resp_host;
  logic [DevSelW-1:0]      dev_sel;
  logic [DevSelW-1:0]      resp_dev;
  logic                    granted;
  logic                    matched;
  logic                    resp_unmapped;
  logic                    resp_active;
  logic [AddressWidth-1:0] req_addr;

  // Descending scan so the lowest requesting index ends up selected.
  always_comb begin
    granted  = 1'b0;
    host_sel = '0;
    for (int h = NrHosts - 1; h >= 0; h--) begin
      if (bus.host_req[h] && !rst_i) begin
        granted  = 1'b1;
        host_sel = HostSelW'(h);
      end
    end
  end

  assign req_addr = bus.host_addr[host_sel];

  always_comb begin
    matched = 1'b0;
    dev_sel = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((req_addr & cfg_device_addr_mask[d]) ==
          cfg_device_addr_base[d]) begin
        matched = 1'b1;
        dev_sel = DevSelW'(d);
      end
    end
  end

  always_comb begin
    bus.host_gnt = '0;
    if (granted) begin
      bus.host_gnt[host_sel] = 1'b1;
    end
  end

  always_comb begin
    bus.device_req   = '0;
    bus.device_addr  = '0;
    bus.device_we    = '0;
    bus.device_be    = '0;
    bus.device_wdata = '0;
    if (granted && matched) begin
      bus.device_req[dev_sel]   = 1'b1;
      bus.device_addr[dev_sel]  = req_addr;
      bus.device_we[dev_sel]    = bus.host_we[host_sel];
      bus.device_be[dev_sel]    = bus.host_be[host_sel];
      bus.device_wdata[dev_sel] = bus.host_wdata[host_sel];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_host     <= '0;
      resp_dev      <= '0;
      resp_unmapped <= 1'b0;
      resp_active   <= 1'b0;
    end else begin
      resp_host     <= host_sel;
      resp_dev      <= dev_sel;
      resp_unmapped <= granted & ~matched;
      resp_active   <= granted;
    end
  end

  // Unmapped accesses answer themselves with an error, no device involved.
  always_comb begin
    bus.host_rvalid = '0;
    bus.host_rdata  = '0;
    bus.host_err    = '0;
    if (resp_active && !rst_i) begin
      if (resp_unmapped) begin
        bus.host_rvalid[resp_host] = 1'b1;
        bus.host_err[resp_host]    = 1'b1;
      end else begin
        bus.host_rvalid[resp_host] = bus.device_rvalid[resp_dev];
        bus.host_rdata[resp_host]  = bus.device_rdata[resp_dev];
        bus.host_err[resp_host]    = bus.device_err[resp_dev];
      end
    end
  end
endmodule

// File: tb/tb_host_device_bus.sv
// Randomised scoreboard bench for host_device_bus (2 hosts, 3 devices).
// Devices are simple memories; expectations come from an address-range model.
module tb_host_device_bus;
  localparam int NH = 2;
  localparam int ND = 3;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  host_device_bus_if #(
    .NrDevices(ND), .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)
  ) bus ();

  logic [ND-1:0][AW-1:0] base;
  logic [ND-1:0][AW-1:0] mask;
  assign base = {32'h0003_0000, 32'h0002_0000, 32'h0010_0000};
  assign mask = {~32'h0000_03FF, ~32'h0000_03FF, ~32'h000F_FFFF};

  host_device_bus #(
    .NrDevices(ND), .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .cfg_device_addr_base(base),
    .cfg_device_addr_mask(mask),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          host;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic        h_req   [NH];
  logic [31:0] h_addr  [NH];
  logic        h_we    [NH];
  logic [3:0]  h_be    [NH];
  logic [31:0] h_wdata [NH];

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Address map as plain ranges.
  function automatic int ref_decode(input logic [31:0] a);
    if (a >= 32'h0010_0000 && a <= 32'h001F_FFFF) return 0;
    if (a >= 32'h0002_0000 && a <= 32'h0002_03FF) return 1;
    if (a >= 32'h0003_0000 && a <= 32'h0003_03FF) return 2;
    return -1;
  endfunction

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h",
               name, cyc, act, exp);
    end
  endtask

  // Device memories: respond one cycle after a request.
  initial begin
    bus.device_rvalid = '0;
    bus.device_rdata  = '0;
    bus.device_err    = '0;
    forever begin
      logic [31:0] a;
      logic [31:0] m;
      logic [31:0] cur;
      @(posedge clk);
      for (int d = 0; d < ND; d++) begin
        bus.device_rvalid[d] = 1'b0;
        bus.device_rdata[d]  = '0;
        bus.device_err[d]    = 1'b0;
        if (!rst && bus.device_req[d]) begin
          a = bus.device_addr[d];
          bus.device_rvalid[d] = 1'b1;
          cur = dev_mem.exists(a) ? dev_mem[a] : dflt(a);
          if (a[7:0] == 8'hF0) begin
            bus.device_err[d] = 1'b1;
          end else if (bus.device_we[d]) begin
            m = {{8{bus.device_be[d][3]}}, {8{bus.device_be[d][2]}},
                 {8{bus.device_be[d][1]}}, {8{bus.device_be[d][0]}}};
            dev_mem[a] = (cur & ~m) | (bus.device_wdata[d] & m);
          end else begin
            bus.device_rdata[d] = cur;
          end
        end
      end
    end
  end

  // Response monitor.
  initial begin
    forever begin
      exp_t e;
      logic [NH-1:0]        erv;
      logic [NH-1:0]        eer;
      logic [NH-1:0][31:0]  erd;
      @(negedge clk);
      if (rst) begin
        while (sb.size() > 0 && sb[0].due <= cyc) void'(sb.pop_front());
        check("rst_quiet", {bus.host_rvalid, bus.host_err, bus.host_rdata},
              '0);
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        erv = '0; eer = '0; erd = '0;
        erv[e.host] = 1'b1;
        eer[e.host] = e.err;
        erd[e.host] = e.rdata;
        check("rvalid", bus.host_rvalid, erv);
        check("rdata", bus.host_rdata, erd);
        check("err", bus.host_err, eer);
      end else begin
        check("idle", {bus.host_rvalid, bus.host_err, bus.host_rdata}, '0);
      end
    end
  end

  task automatic apply();
    for (int h = 0; h < NH; h++) begin
      bus.host_req[h]   = h_req[h];
      bus.host_addr[h]  = h_addr[h];
      bus.host_we[h]    = h_we[h];
      bus.host_be[h]    = h_be[h];
      bus.host_wdata[h] = h_wdata[h];
    end
  endtask

  task automatic set_host(input int h, input logic r, input logic [31:0] a,
                          input logic w, input logic [3:0] be,
                          input logic [31:0] wd);
    h_req[h] = r; h_addr[h] = a; h_we[h] = w;
    h_be[h] = be; h_wdata[h] = wd;
  endtask

  // Checks the request path, queues the expected response, advances a cycle.
  task automatic cycle_check();
    int w;
    int d;
    exp_t e;
    logic [31:0]         cur;
    logic [NH-1:0]       egnt;
    logic [ND-1:0]       ereq;
    logic [ND-1:0]       ewe;
    logic [ND-1:0][3:0]  ebe;
    logic [ND-1:0][31:0] eaddr;
    logic [ND-1:0][31:0] ewd;
    apply();
    @(negedge clk);
    w = -1;
    for (int h = NH - 1; h >= 0; h--) if (h_req[h] && !rst) w = h;
    d = (w >= 0) ? ref_decode(h_addr[w]) : -1;
    egnt = '0; ereq = '0; ewe = '0; ebe = '0; eaddr = '0; ewd = '0;
    if (w >= 0) egnt[w] = 1'b1;
    if (d >= 0) begin
      ereq[d] = 1'b1; eaddr[d] = h_addr[w]; ewe[d] = h_we[w];
      ebe[d] = h_be[w]; ewd[d] = h_wdata[w];
    end
    check("gnt", bus.host_gnt, egnt);
    check("dev_req", bus.device_req, ereq);
    check("dev_addr", bus.device_addr, eaddr);
    check("dev_we_be", {bus.device_we, bus.device_be}, {ewe, ebe});
    check("dev_wdata", bus.device_wdata, ewd);
    if (w >= 0) begin
      e.host = w; e.rdata = '0; e.err = 1'b0; e.due = cyc + 1;
      cur = ref_mem.exists(h_addr[w]) ? ref_mem[h_addr[w]]
                                      : dflt(h_addr[w]);
      if (d < 0 || h_addr[w][7:0] == 8'hF0) begin
        e.err = 1'b1;
      end else if (h_we[w]) begin
        for (int b = 0; b < 4; b++)
          if (h_be[w][b]) cur[8*b +: 8] = h_wdata[w][8*b +: 8];
        ref_mem[h_addr[w]] = cur;
      end else begin
        e.rdata = cur;
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_addr();
    int sel;
    logic [31:0] off;
    sel = $urandom_range(0, 9);
    off = ($urandom_range(0, 7) == 0) ? 32'hF0 : 32'($urandom_range(0, 7) * 4);
    if (sel < 3) return 32'h0010_0000 + off;
    if (sel < 6) return 32'h0002_0000 + off;
    if (sel < 9) return 32'h0003_0000 + off;
    case ($urandom_range(0, 2))
      0:       return 32'h0005_0000;
      1:       return 32'h0002_0400;
      default: return 32'h000F_FFFC;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    for (int h = 0; h < NH; h++) set_host(h, 0, '0, 0, '0, '0);
    apply();
    @(posedge clk);
    #1;
    cycle_check();
    cycle_check();
    rst = 1'b0;

    set_host(0, 1, 32'h0010_0010, 1, 4'hF, 32'hDEAD_BEEF);
    cycle_check();
    set_host(0, 1, 32'h0010_0010, 0, 4'hF, 32'h0);
    cycle_check();
    set_host(0, 1, 32'h0002_0000, 1, 4'h1, 32'h41);
    cycle_check();
    set_host(0, 1, 32'h0003_0004, 0, 4'hF, 32'h0);
    set_host(1, 1, 32'h0002_0000, 0, 4'hF, 32'h0);
    cycle_check();
    set_host(0, 0, '0, 0, '0, '0);
    cycle_check();
    set_host(1, 0, '0, 0, '0, '0);
    set_host(0, 1, 32'h0005_0000, 0, 4'hF, 32'h0);
    cycle_check();
    set_host(0, 1, 32'h0003_0004, 0, 4'hF, 32'h0);
    cycle_check();
    set_host(0, 1, 32'h0010_0000, 0, 4'hF, 32'h0);
    cycle_check();
    set_host(0, 1, 32'h0010_0010, 0, 4'hF, 32'h0);
    cycle_check();
    rst = 1'b1;
    cycle_check();
    cycle_check();
    rst = 1'b0;
    set_host(0, 0, '0, 0, '0, '0);
    cycle_check();

    for (int i = 0; i < 400; i++) begin
      for (int h = 0; h < NH; h++)
        set_host(h, $urandom_range(0, 99) < 60, pick_addr(),
                 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                 $urandom);
      rst = ($urandom_range(0, 99) < 2);
      cycle_check();
    end
    rst = 1'b0;
    for (int h = 0; h < NH; h++) set_host(h, 0, '0, 0, '0, '0);
    cycle_check();
    cycle_check();
    check("drained", 128'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
